seg7_scan_decoder: RTL

//   Receive side of the team's 7-segment display encoding. Monitors a time-multiplexed,

---
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed active-low 7-segment display and its scan decoder:
// the pins being watched plus the recovered digit values and event pulses.
interface seg7_scan_if #(
    parameter int NDIG = 4
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic              upd;
    logic [IDX_W-1:0]  upd_idx;
    logic              err;

    modport master (
        output seg, an,
        input  digits, valid, upd, upd_idx, err
    );

    modport slave (
        input  seg, an,
        output digits, valid, upd, upd_idx, err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex nibbles from a time-multiplexed active-low 7-segment bus,
// committing a digit only after STABLE identical scan visits.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(STABLE + 1);
    // candidate encoding {blank, nibble}; 11111 can never come out of the decoder
    localparam logic [4:0] CAND_NONE = 5'b11111;
    localparam logic [4:0] CAND_BLANK = 5'b10000;

    // returns {legal, blank, nibble}
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: seg_decode = 6'b10_0000;
            7'b1001111: seg_decode = 6'b10_0001;
            7'b0010010: seg_decode = 6'b10_0010;
            7'b0000110: seg_decode = 6'b10_0011;
            7'b1001100: seg_decode = 6'b10_0100;
            7'b0100100: seg_decode = 6'b10_0101;
            7'b0100000: seg_decode = 6'b10_0110;
            7'b0001111: seg_decode = 6'b10_0111;
            7'b0000000: seg_decode = 6'b10_1000;
            7'b0000100: seg_decode = 6'b10_1001;
            7'b0001000: seg_decode = 6'b10_1010;
            7'b1100000: seg_decode = 6'b10_1011;
            7'b0110001: seg_decode = 6'b10_1100;
            7'b1000010: seg_decode = 6'b10_1101;
            7'b0110000: seg_decode = 6'b10_1110;
            7'b0111000: seg_decode = 6'b10_1111;
            7'b1111111: seg_decode = 6'b11_0000;
            default:    seg_decode = 6'b00_0000;
        endcase
    endfunction

    logic [6:0]       seg_p0;
    logic [NDIG-1:0]  an_p0;
    logic [NDIG-1:0]  an_p1;

    logic [4:0]       cand    [NDIG];
    logic [CNT_W-1:0] cnt     [NDIG];
    logic [3:0]       digit_q [NDIG];
    logic [NDIG-1:0]  valid_q;
    logic             upd_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic             err_q;

    logic [IDX_W:0]   nlow;
    logic [IDX_W-1:0] vis_idx;
    logic             an_chg;
    logic             vld_p0;
    logic             multi_p0;
    logic [5:0]       dec;
    logic             legal;
    logic [4:0]       code;
    logic [4:0]       cur_cand;
    logic [CNT_W-1:0] cur_cnt;
    logic [4:0]       cur_commit;
    logic [4:0]       nxt_cand;
    logic [CNT_W-1:0] nxt_cnt;
    logic             commit;

    // ---- stage p0: pin capture, previous select kept for edge detection ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= '1;
            an_p0  <= '1;
            an_p1  <= '1;
        end else begin
            seg_p0 <= bus.seg;
            an_p0  <= bus.an;
            an_p1  <= an_p0;
        end
    end

    always_comb begin
        nlow    = '0;
        vis_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_p0[i]) begin
                nlow    = nlow + (IDX_W + 1)'(1);
                vis_idx = IDX_W'(i);
            end
        end
        an_chg   = (an_p0 != an_p1);
        vld_p0   = an_chg && (nlow == (IDX_W + 1)'(1));
        multi_p0 = an_chg && (nlow > (IDX_W + 1)'(1));

        dec      = seg_decode(seg_p0);
        legal    = dec[5];
        code     = dec[4:0];
        cur_cand = cand[vis_idx];
        cur_cnt  = cnt[vis_idx];
        cur_commit = valid_q[vis_idx] ? {1'b0, digit_q[vis_idx]} : CAND_BLANK;

        nxt_cand = cur_cand;
        nxt_cnt  = cur_cnt;
        if (!legal) begin
            nxt_cand = CAND_NONE;
            nxt_cnt  = '0;
        end else if (code == cur_cand) begin
            if (cur_cnt != CNT_W'(STABLE))
                nxt_cnt = cur_cnt + CNT_W'(1);
        end else begin
            nxt_cand = code;
            nxt_cnt  = CNT_W'(1);
        end
        // once saturated the committed value already equals cand, so re-visits never re-fire
        commit = vld_p0 && legal && (nxt_cnt == CNT_W'(STABLE)) && (nxt_cand != cur_commit);
    end

    // ---- stage p1: debounce state and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                cand[i]    <= CAND_NONE;
                cnt[i]     <= '0;
                digit_q[i] <= '0;
            end
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
            if (vld_p0) begin
                cand[vis_idx] <= nxt_cand;
                cnt[vis_idx]  <= nxt_cnt;
                err_q         <= !legal;
                if (commit) begin
                    upd_q     <= 1'b1;
                    upd_idx_q <= vis_idx;
                    if (nxt_cand[4]) begin
                        valid_q[vis_idx] <= 1'b0;
                    end else begin
                        digit_q[vis_idx] <= nxt_cand[3:0];
                        valid_q[vis_idx] <= 1'b1;
                    end
                end
            end else if (multi_p0) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_pack
        assign bus.digits[4*g +: 4] = digit_q[g];
    end
    assign bus.valid   = valid_q;
    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
    assign bus.err     = err_q;
endmodule
